// File: rtl/core_pkg.sv
// Shared types and constants for the 9-bit-instruction core.
package core_pkg;

  localparam int unsigned INSTR_W = 9;

  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_BR   = 3'b010;
  localparam logic [2:0] OP_MEM  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } fsm_state_t;

endpackage : core_pkg

// File: rtl/next_pc_calc.sv
// Combinational next-PC adder with program-range check.
// The sum is formed signed, two bits wider than the PC, so that both
// backward underflow and forward overflow are visible to the range check.
module next_pc_calc #(
  parameter int PC_W       = 10,
  parameter int PROG_DEPTH = 1024
) (
  input  logic [PC_W-1:0] pc,
  input  logic            branch_sel,
  input  logic [7:0]      branch_offset,
  output logic [PC_W-1:0] target,
  output logic            out_of_range
);

  localparam int SUM_W = PC_W + 2;
  localparam logic signed [SUM_W-1:0] DEPTH_S = SUM_W'(PROG_DEPTH);
  localparam logic signed [SUM_W-1:0] ONE_S   = SUM_W'(1);

  logic signed [SUM_W-1:0] pc_ext_s;
  logic signed [SUM_W-1:0] off_ext_s;
  logic signed [SUM_W-1:0] sum_s;

  // Widen operands, add, and flag any target outside [0, PROG_DEPTH).
  always_comb begin
    pc_ext_s = {2'b00, pc};
    if (branch_sel) begin
      off_ext_s = {{(SUM_W-8){branch_offset[7]}}, branch_offset};
    end else begin
      off_ext_s = '0;
    end
    sum_s        = pc_ext_s + ONE_S + off_ext_s;
    target       = sum_s[PC_W-1:0];
    out_of_range = sum_s[SUM_W-1] | (sum_s >= DEPTH_S);
  end

endmodule : next_pc_calc

// File: rtl/fetch_sequencer.sv
// Instruction-fetch / program-counter sequencer: launches a program from one
// of four start addresses, steps or branches the PC each RUN cycle, halts on
// the terminate op or an out-of-range target, and counts RUN cycles.
module fetch_sequencer
  import core_pkg::*;
#(
  parameter int PC_W       = 10,
  parameter int PROG_DEPTH = 1024,
  parameter int START0     = 0,
  parameter int START1     = 256,
  parameter int START2     = 512,
  parameter int START3     = 768,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         prog_sel,
  input  logic               next_branch_selector,
  input  logic [7:0]         branch_offset,
  input  logic               done,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr_out,
  output logic               exec_en,
  output logic               halted,
  output logic               fault,
  output logic [CNT_W-1:0]   cycle_count
);

  fsm_state_t       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             halted_q, halted_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             exec_en_q, exec_en_d;

  logic [PC_W-1:0]  start_addr_s;
  logic [PC_W-1:0]  target_s;
  logic             out_of_range_s;
  logic [CNT_W-1:0] cnt_inc_s;

  next_pc_calc #(
    .PC_W       (PC_W),
    .PROG_DEPTH (PROG_DEPTH)
  ) u_next_pc_calc (
    .pc            (pc_q),
    .branch_sel    (next_branch_selector),
    .branch_offset (branch_offset),
    .target        (target_s),
    .out_of_range  (out_of_range_s)
  );

  // Launch address for the selected program.
  always_comb begin
    case (prog_sel)
      2'd0:    start_addr_s = PC_W'(START0);
      2'd1:    start_addr_s = PC_W'(START1);
      2'd2:    start_addr_s = PC_W'(START2);
      2'd3:    start_addr_s = PC_W'(START3);
      default: start_addr_s = PC_W'(START0);
    endcase
  end

  // Saturating increment of the RUN-cycle counter.
  always_comb begin
    if (cnt_q == {CNT_W{1'b1}}) begin
      cnt_inc_s = cnt_q;
    end else begin
      cnt_inc_s = cnt_q + CNT_W'(1);
    end
  end

  // Next-state and next-PC logic; priority in RUN is abort, done, fault, step.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    fault_d  = fault_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        pc_d     = start_addr_s;
        halted_d = 1'b0;
        fault_d  = 1'b0;
        cnt_d    = '0;
        if (start) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_inc_s;
        if (start) begin
          state_d = ST_LOAD;
        end else if (done) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end else if (out_of_range_s) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
          fault_d  = 1'b1;
        end else begin
          pc_d = target_s;
        end
      end
      ST_HALT: begin
        if (start) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    exec_en_d = (state_d == ST_RUN);
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
      cnt_q     <= '0;
      exec_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      halted_q  <= halted_d;
      fault_q   <= fault_d;
      cnt_q     <= cnt_d;
      exec_en_q <= exec_en_d;
    end
  end

  // Pass the ROM word through only once a program is executing or halted,
  // so the decoder never sees a live opcode while idle or loading.
  always_comb begin
    if ((state_q == ST_RUN) || (state_q == ST_HALT)) begin
      instr_out = instr_in;
    end else begin
      instr_out = '0;
    end
  end

  assign pc          = pc_q;
  assign exec_en     = exec_en_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign cycle_count = cnt_q;

endmodule : fetch_sequencer
